// File: rtl/integer_datapath.sv
// Integer execution datapath: 32x32 register file, combinational ALU with
// 64-bit multiply/divide, HI/LO result registers and the write-back mux.

module integer_datapath_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  s_addr,
  input  logic [4:0]  t_addr,
  input  logic [4:0]  d_addr,
  input  logic        d_en,
  input  logic [31:0] d_in,
  output logic [31:0] s,
  output logic [31:0] t
);
  logic [31:0] REG [0:31];

  // Write port: reset clears every word; writes to R0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) REG[i] <= '0;
    end else if (d_en && (d_addr != 5'd0)) begin
      REG[d_addr] <= d_in;
    end
  end

  // R0 is forced to zero on read so a stale value can never leak out.
  assign s = (s_addr == 5'd0) ? 32'h0 : REG[s_addr];
  assign t = (t_addr == 5'd0) ? 32'h0 : REG[t_addr];
endmodule

module integer_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  S_Addr,
  input  logic [4:0]  T_Addr,
  input  logic [4:0]  D_Addr,
  input  logic        D_en,
  input  logic [31:0] DT,
  input  logic        T_sel,
  input  logic [4:0]  FS,
  input  logic        HILO_ld,
  input  logic [31:0] DY,
  input  logic [31:0] PC_in,
  input  logic [2:0]  Y_sel,
  output logic [31:0] ALU_out,
  output logic        C,
  output logic        N,
  output logic        V,
  output logic        Z
);
  localparam logic [4:0] OP_PASS_S = 5'h00, OP_PASS_B = 5'h01, OP_ADD  = 5'h02,
                         OP_ADDU   = 5'h03, OP_SUB    = 5'h04, OP_SUBU = 5'h05,
                         OP_SLT    = 5'h06, OP_SLTU   = 5'h07, OP_AND  = 5'h08,
                         OP_OR     = 5'h09, OP_XOR    = 5'h0A, OP_NOR  = 5'h0B,
                         OP_SLL    = 5'h0C, OP_SRL    = 5'h0D, OP_SRA  = 5'h0E,
                         OP_INC    = 5'h0F, OP_DEC    = 5'h10, OP_INC4 = 5'h11,
                         OP_DEC4   = 5'h12, OP_ZEROS  = 5'h13, OP_ONES = 5'h14,
                         OP_K3FC   = 5'h15, OP_ANDI   = 5'h16, OP_ORI  = 5'h17,
                         OP_LUI    = 5'h18, OP_XORI   = 5'h19, OP_MUL  = 5'h1E,
                         OP_DIV    = 5'h1F;

  logic [31:0] s_val, t_val, a, b;
  logic [31:0] y_hi, y_lo;
  logic [31:0] hi_q, lo_q;
  logic [32:0] sum33;
  logic        c_raw, v_raw, unused_op;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  integer_datapath_regfile regfile (
    .clk    (clk),
    .reset  (reset),
    .s_addr (S_Addr),
    .t_addr (T_Addr),
    .d_addr (D_Addr),
    .d_en   (D_en),
    .d_in   (ALU_out),
    .s      (s_val),
    .t      (t_val)
  );

  assign a = s_val;
  assign b = T_sel ? t_val : DT;

  // Multiply and divide are computed every cycle; the case below picks them up.
  always_comb begin
    prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    quo  = '0;
    rem  = '0;
    if (b == 32'h0) begin
      quo = '1;
      rem = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      // The one signed quotient that does not fit; wrap it instead of trapping.
      quo = a;
      rem = '0;
    end else begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
  end

  // ALU result halves plus raw carry/overflow before the unused-code mask.
  always_comb begin
    y_hi      = '0;
    y_lo      = '0;
    c_raw     = 1'b0;
    v_raw     = 1'b0;
    unused_op = 1'b0;
    sum33     = '0;
    case (FS)
      OP_PASS_S: y_lo = a;
      OP_PASS_B: y_lo = b;
      OP_ADD, OP_ADDU: begin
        sum33 = {1'b0, a} + {1'b0, b};
        y_lo  = sum33[31:0];
        c_raw = sum33[32];
        v_raw = (FS == OP_ADD) && (a[31] == b[31]) && (y_lo[31] != a[31]);
      end
      OP_SUB, OP_SUBU: begin
        y_lo  = a - b;
        c_raw = (a < b);
        v_raw = (FS == OP_SUB) && (a[31] != b[31]) && (y_lo[31] != a[31]);
      end
      OP_SLT:  y_lo = {31'h0, ($signed(a) < $signed(b))};
      OP_SLTU: begin
        y_lo  = {31'h0, (a < b)};
        c_raw = (a < b);
      end
      OP_AND: y_lo = a & b;
      OP_OR:  y_lo = a | b;
      OP_XOR: y_lo = a ^ b;
      OP_NOR: y_lo = ~(a | b);
      OP_SLL: begin
        y_lo  = {b[30:0], 1'b0};
        c_raw = b[31];
      end
      OP_SRL: begin
        y_lo  = {1'b0, b[31:1]};
        c_raw = b[0];
      end
      OP_SRA: begin
        y_lo  = {b[31], b[31:1]};
        c_raw = b[0];
      end
      OP_INC, OP_INC4: begin
        sum33 = {1'b0, a} + ((FS == OP_INC) ? 33'd1 : 33'd4);
        y_lo  = sum33[31:0];
        c_raw = sum33[32];
        v_raw = ~a[31] & y_lo[31];
      end
      OP_DEC, OP_DEC4: begin
        y_lo  = a - ((FS == OP_DEC) ? 32'd1 : 32'd4);
        c_raw = (a < ((FS == OP_DEC) ? 32'd1 : 32'd4));
        v_raw = a[31] & ~y_lo[31];
      end
      OP_ZEROS: y_lo = 32'h0;
      OP_ONES:  y_lo = 32'hFFFF_FFFF;
      OP_K3FC:  y_lo = 32'h0000_03FC;
      OP_ANDI:  y_lo = a & {16'h0, b[15:0]};
      OP_ORI:   y_lo = a | {16'h0, b[15:0]};
      OP_LUI:   y_lo = {b[15:0], 16'h0};
      OP_XORI:  y_lo = a ^ {16'h0, b[15:0]};
      OP_MUL: begin
        y_hi = prod[63:32];
        y_lo = prod[31:0];
      end
      OP_DIV: begin
        y_hi = rem;
        y_lo = quo;
      end
      default: unused_op = 1'b1;
    endcase
  end

  // Flags; unused function codes report all-zero flags, including Z.
  always_comb begin
    C = 1'b0;
    N = 1'b0;
    V = 1'b0;
    Z = 1'b0;
    if (!unused_op) begin
      C = c_raw;
      V = v_raw;
      N = (FS == OP_MUL || FS == OP_DIV) ? y_hi[31] : y_lo[31];
      Z = (FS == OP_MUL) ? ({y_hi, y_lo} == 64'h0) : (y_lo == 32'h0);
    end
  end

  // HI/LO capture the 64-bit result and hold it until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (HILO_ld) begin
      hi_q <= y_hi;
      lo_q <= y_lo;
    end
  end

  // Write-back select; the spare codes fall back to the ALU low word.
  always_comb begin
    ALU_out = y_lo;
    case (Y_sel)
      3'b001:  ALU_out = lo_q;
      3'b010:  ALU_out = hi_q;
      3'b011:  ALU_out = DY;
      3'b100:  ALU_out = PC_in;
      default: ALU_out = y_lo;
    endcase
  end
endmodule

// File: tb/tb_integer_datapath.sv
module tb_integer_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  S_Addr, T_Addr, D_Addr, FS;
  logic        D_en, T_sel, HILO_ld;
  logic [31:0] DT, DY, PC_in;
  logic [2:0]  Y_sel;
  logic [31:0] ALU_out;
  logic        C, N, V, Z;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  integer_datapath dut (
    .clk(clk), .reset(reset), .S_Addr(S_Addr), .T_Addr(T_Addr), .D_Addr(D_Addr),
    .D_en(D_en), .DT(DT), .T_sel(T_sel), .FS(FS), .HILO_ld(HILO_ld), .DY(DY),
    .PC_in(PC_in), .Y_sel(Y_sel), .ALU_out(ALU_out), .C(C), .N(N), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    S_Addr = 0; T_Addr = 0; D_Addr = 0; D_en = 0; DT = 0; T_sel = 0;
    FS = 0; HILO_ld = 0; DY = 0; PC_in = 0; Y_sel = 0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    #1;
    compare(ALU_out);
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic n,
                           input logic v, input logic z);
    push_exp({tag, "_C"}, {31'h0, c});
    push_exp({tag, "_N"}, {31'h0, n});
    push_exp({tag, "_V"}, {31'h0, v});
    push_exp({tag, "_Z"}, {31'h0, z});
    #1;
    compare({31'h0, C});
    compare({31'h0, N});
    compare({31'h0, V});
    compare({31'h0, Z});
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
    push_exp(tag, v);
    S_Addr = r; FS = 5'h00; Y_sel = 3'b000; D_en = 0; HILO_ld = 0;
    #1;
    compare(ALU_out);
  endtask

  // Three-edge MUL/DIV sequence with the ALU inputs already driven.
  task automatic muldiv_wb(input logic [4:0] hi_dst, input logic [4:0] lo_dst);
    @(negedge clk);
    HILO_ld = 1; D_en = 0; Y_sel = 3'b000;
    tick();
    HILO_ld = 0; Y_sel = 3'b010; D_Addr = hi_dst; D_en = 1;
    tick();
    Y_sel = 3'b001; D_Addr = lo_dst;
    tick();
    D_en = 0; Y_sel = 3'b000;
  endtask

  initial begin
    logic [31:0] pat;
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_out("reset_out", 32'h0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Preload every register and read each one back through PASS_S.
    for (int i = 0; i < 32; i++) dut.regfile.REG[i] = 32'h1000_0001 * i ^ 32'h5A5A_0000;
    dut.regfile.REG[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) begin
      pat = (i == 0) ? 32'h0 : (32'h1000_0001 * i ^ 32'h5A5A_0000);
      chk_reg($sformatf("read_r%0d", i), i[4:0], pat);
    end

    // OR into R1.
    dut.regfile.REG[3] = 32'h0000_00F0;
    dut.regfile.REG[4] = 32'h0000_000F;
    @(negedge clk);
    idle();
    FS = 5'h09; S_Addr = 3; T_Addr = 4; T_sel = 1; D_Addr = 1; D_en = 1;
    chk_out("or_out", 32'h0000_00FF);
    chk_flags("or", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_reg("or_r1", 1, 32'h0000_00FF);

    // SUB 0 - R10 written back into R10 (no bypass: the edge uses the old R10).
    dut.regfile.REG[10] = 32'd5;
    @(negedge clk);
    idle();
    FS = 5'h04; S_Addr = 0; T_Addr = 10; T_sel = 1; D_Addr = 10; D_en = 1;
    chk_flags("sub", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    D_en = 0;
    chk_reg("sub_r10", 10, 32'hFFFF_FFFB);

    // Signed overflow on ADD and carry-out on ADDU.
    dut.regfile.REG[2] = 32'h7FFF_FFFF;
    dut.regfile.REG[20] = 32'hFFFF_FFFF;
    idle();
    FS = 5'h02; S_Addr = 2; DT = 32'd1; T_sel = 0;
    chk_out("add_ovf_out", 32'h8000_0000);
    chk_flags("add_ovf", 1'b0, 1'b1, 1'b1, 1'b0);
    FS = 5'h03; S_Addr = 20;
    chk_flags("addu_carry", 1'b1, 1'b0, 1'b0, 1'b1);

    // Shifts of 0x80000001.
    dut.regfile.REG[4] = 32'h8000_0001;
    dut.regfile.REG[5] = 32'h8000_0001;
    idle();
    FS = 5'h0D; T_Addr = 4; T_sel = 1;
    chk_out("srl_out", 32'h4000_0000);
    chk_flags("srl", 1'b1, 1'b0, 1'b0, 1'b0);
    FS = 5'h0C; T_Addr = 5;
    chk_out("sll_out", 32'h0000_0002);
    chk_flags("sll", 1'b1, 1'b0, 1'b0, 1'b0);
    FS = 5'h0E;
    chk_out("sra_out", 32'hC000_0000);

    // DIV 100 / 7 -> HI into R6, LO into R5.
    dut.regfile.REG[15] = 32'd100;
    dut.regfile.REG[14] = 32'd7;
    idle();
    FS = 5'h1F; S_Addr = 15; T_Addr = 14; T_sel = 1;
    muldiv_wb(6, 5);
    chk_reg("div_hi_r6", 6, 32'd2);
    chk_reg("div_lo_r5", 5, 32'd14);

    // DIV -7 / 2 truncates toward zero, remainder follows the dividend.
    dut.regfile.REG[16] = 32'hFFFF_FFF9;
    dut.regfile.REG[17] = 32'd2;
    idle();
    FS = 5'h1F; S_Addr = 16; T_Addr = 17; T_sel = 1;
    chk_flags("div_neg", 1'b0, 1'b1, 1'b0, 1'b0);
    muldiv_wb(18, 19);
    chk_reg("div_neg_hi", 18, 32'hFFFF_FFFF);
    chk_reg("div_neg_lo", 19, 32'hFFFF_FFFD);

    // Divide by zero: quotient all ones, remainder is the dividend.
    idle();
    FS = 5'h1F; S_Addr = 15; DT = 32'h0; T_sel = 0;
    chk_out("div0_lo", 32'hFFFF_FFFF);
    @(negedge clk);
    HILO_ld = 1;
    tick();
    HILO_ld = 0; Y_sel = 3'b010;
    chk_out("div0_hi", 32'd100);

    // MUL 3 * -5 -> HI into R8, LO into R7; HI/LO hold afterwards.
    dut.regfile.REG[11] = 32'd3;
    idle();
    FS = 5'h1E; S_Addr = 11; DT = 32'hFFFF_FFFB; T_sel = 0;
    chk_flags("mul", 1'b0, 1'b1, 1'b0, 1'b0);
    muldiv_wb(8, 7);
    chk_reg("mul_hi_r8", 8, 32'hFFFF_FFFF);
    chk_reg("mul_lo_r7", 7, 32'hFFFF_FFF1);
    tick();
    FS = 5'h14; Y_sel = 3'b001;
    chk_out("lo_hold", 32'hFFFF_FFF1);

    // Mux sources DY and PC_in.
    @(negedge clk);
    idle();
    Y_sel = 3'b011; DY = 32'hABCD_EF01; D_Addr = 12; D_en = 1;
    tick();
    chk_reg("dy_r12", 12, 32'hABCD_EF01);
    @(negedge clk);
    idle();
    Y_sel = 3'b100; PC_in = 32'h1001_00C0; D_Addr = 13; D_en = 1;
    tick();
    chk_reg("pc_r13", 13, 32'h1001_00C0);
    idle();
    FS = 5'h14; Y_sel = 3'b111;
    chk_out("ysel7_ylo", 32'hFFFF_FFFF);

    // Unused function code: result 0 but every flag clear.
    idle();
    FS = 5'h1A; S_Addr = 12;
    chk_out("unused_out", 32'h0);
    chk_flags("unused", 1'b0, 1'b0, 1'b0, 1'b0);

    // Write to R0 is discarded.
    @(negedge clk);
    idle();
    Y_sel = 3'b011; DY = 32'h1234_5678; D_Addr = 0; D_en = 1;
    tick();
    chk_reg("r0_write", 0, 32'h0);

    // Reset wins over a simultaneous write and HI/LO load.
    @(negedge clk);
    idle();
    reset = 1; FS = 5'h14; HILO_ld = 1; Y_sel = 3'b011; DY = 32'hFFFF_0000;
    D_Addr = 1; D_en = 1;
    tick();
    reset = 0;
    idle();
    for (int i = 0; i < 32; i++) chk_reg($sformatf("rst_r%0d", i), i[4:0], 32'h0);
    Y_sel = 3'b001;
    chk_out("rst_lo", 32'h0);
    Y_sel = 3'b010;
    chk_out("rst_hi", 32'h0);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
